// File: rtl/spi_shift_reg_if.sv
// rtl/spi_shift_reg_if.sv - Handshake and data bundle between SPI master control, clkgen and shift register.
interface spi_shift_reg_if #(
    parameter int MAX_LEN   = 32,
    parameter int LEN_WIDTH = $clog2(MAX_LEN)
);
    logic                 go;
    logic [LEN_WIDTH-1:0] len;
    logic                 lsb;
    logic [MAX_LEN-1:0]   tx_data;
    logic                 shift;
    logic                 sample;
    logic                 miso;
    logic                 tip;
    logic                 mosi;
    logic                 done;
    logic [MAX_LEN-1:0]   rx_data;

    modport master (
        output go, len, lsb, tx_data, shift, sample, miso,
        input  tip, mosi, done, rx_data
    );

    modport slave (
        input  go, len, lsb, tx_data, shift, sample, miso,
        output tip, mosi, done, rx_data
    );
endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - SPI master serialiser/deserialiser driven by clkgen shift/sample pulses.
module spi_shift_reg #(
    parameter int MAX_LEN   = 32,
    parameter int LEN_WIDTH = $clog2(MAX_LEN)
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    spi_shift_reg_if.slave bus
);
    typedef enum logic {IDLE, XFER} state_t;
    typedef logic [LEN_WIDTH:0] cnt_t;

    localparam cnt_t MAX_L = cnt_t'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] txd_q, txd_d;
    logic [MAX_LEN-1:0] rx_data_q, rx_data_d;
    cnt_t               len_q, len_d;
    cnt_t               tx_idx_q, tx_idx_d;
    cnt_t               rx_cnt_q, rx_cnt_d;
    logic               lsb_q, lsb_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;

    // Maps a transfer-order index onto a word bit position for the latched bit order.
    function automatic logic [LEN_WIDTH-1:0] bit_pos(cnt_t l, logic lsb_first, cnt_t idx);
        cnt_t p;
        p = lsb_first ? idx : (l - cnt_t'(1) - idx);
        return p[LEN_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        rx_data_d = rx_data_q;
        len_d     = len_q;
        tx_idx_d  = tx_idx_q;
        rx_cnt_d  = rx_cnt_q;
        lsb_d     = lsb_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    txd_d     = bus.tx_data;
                    len_d     = (bus.len == '0) ? MAX_L : cnt_t'(bus.len);
                    lsb_d     = bus.lsb;
                    rx_data_d = '0;
                    tx_idx_d  = '0;
                    rx_cnt_d  = '0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (bus.sample) begin
                    rx_data_d[bit_pos(len_q, lsb_q, rx_cnt_q)] = bus.miso;
                    rx_cnt_d = rx_cnt_q + cnt_t'(1);
                end
                // A shift only advances once the current bit has been sampled (CPHA=1 leading edge).
                if (bus.shift && (rx_cnt_d > tx_idx_q) && (tx_idx_q != len_q - cnt_t'(1)))
                    tx_idx_d = tx_idx_q + cnt_t'(1);
                if (rx_cnt_d == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Looking at next-state values puts bit 0 on mosi in the very first XFER cycle.
        mosi_d = (state_d == XFER) ? txd_d[bit_pos(len_d, lsb_d, tx_idx_d)] : 1'b0;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            txd_q     <= '0;
            rx_data_q <= '0;
            len_q     <= '0;
            tx_idx_q  <= '0;
            rx_cnt_q  <= '0;
            lsb_q     <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            rx_data_q <= rx_data_d;
            len_q     <= len_d;
            tx_idx_q  <= tx_idx_d;
            rx_cnt_q  <= rx_cnt_d;
            lsb_q     <= lsb_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign bus.tip     = (state_q == XFER);
    assign bus.mosi    = mosi_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_shift_reg.sv
// tb/tb_spi_shift_reg.sv - Scoreboard bench for spi_shift_reg with a pulse-level clkgen model.
module tb_spi_shift_reg;
    localparam int MAX_LEN = 32;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic        exp_mosi_q[$];
    logic [31:0] exp_rx_q[$];

    spi_shift_reg_if #(.MAX_LEN(MAX_LEN)) bus ();

    spi_shift_reg #(.MAX_LEN(MAX_LEN)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic pulse_shift();
        bus.shift = 1'b1;
        @(negedge sys_clk);
        bus.shift = 1'b0;
    endtask

    // miso_mode: 0 loopback of mosi, 1 tied high, 2 bit i of miso_vec on sample i.
    task automatic xfer(input int nbits, input logic lsb_i, input logic [31:0] tx,
                        input bit cpha, input int miso_mode, input logic [31:0] miso_vec,
                        input int stop_after, input bit inject_go, input string name);
        logic [31:0] exp_rx;
        logic [31:0] want_rx;
        logic        m;
        logic        eb;
        int          pos;
        exp_rx = '0;
        for (int i = 0; i < nbits; i++) begin
            pos = lsb_i ? i : nbits - 1 - i;
            exp_mosi_q.push_back(tx[pos]);
            case (miso_mode)
                0:       m = tx[pos];
                1:       m = 1'b1;
                default: m = miso_vec[i];
            endcase
            exp_rx[pos] = m;
        end
        exp_rx_q.push_back(exp_rx);

        bus.go      = 1'b1;
        bus.len     = 5'(nbits);
        bus.lsb     = lsb_i;
        bus.tx_data = tx;
        @(negedge sys_clk);
        bus.go      = 1'b0;
        bus.tx_data = ~tx;
        bus.len     = 5'(nbits + 1);
        bus.lsb     = ~lsb_i;
        checks++;
        if (bus.tip !== 1'b1) begin
            errors++;
            $display("FAIL %s tip_rise got %b want 1", name, bus.tip);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_at_start got %b want 0", name, bus.done);
        end

        for (int i = 0; i < nbits; i++) begin
            if (stop_after > 0 && i == stop_after) return;
            if (cpha) begin
                @(negedge sys_clk);
                pulse_shift();
            end
            @(negedge sys_clk);
            if (inject_go && i == nbits / 2) begin
                bus.go      = 1'b1;
                bus.tx_data = 32'h0;
                @(negedge sys_clk);
                bus.go = 1'b0;
            end
            eb = exp_mosi_q.pop_front();
            checks++;
            if (bus.mosi !== eb) begin
                errors++;
                $display("FAIL %s mosi bit %0d got %b want %b", name, i, bus.mosi, eb);
            end
            checks++;
            if (bus.tip !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s mid_xfer bit %0d tip %b done %b want tip 1 done 0",
                         name, i, bus.tip, bus.done);
            end
            case (miso_mode)
                0:       bus.miso = bus.mosi;
                1:       bus.miso = 1'b1;
                default: bus.miso = miso_vec[i];
            endcase
            bus.sample = 1'b1;
            @(negedge sys_clk);
            bus.sample = 1'b0;
            if (!cpha && i < nbits - 1) begin
                @(negedge sys_clk);
                pulse_shift();
            end
        end

        want_rx = exp_rx_q.pop_front();
        checks++;
        if (bus.done !== 1'b1 || bus.tip !== 1'b0) begin
            errors++;
            $display("FAIL %s end done %b tip %b want done 1 tip 0", name, bus.done, bus.tip);
        end
        checks++;
        if (bus.rx_data !== want_rx) begin
            errors++;
            $display("FAIL %s rx_data got %h want %h", name, bus.rx_data, want_rx);
        end
        checks++;
        if (bus.mosi !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_mosi got %b want 0", name, bus.mosi);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        checks++;
        if (bus.tip !== 1'b0 || bus.mosi !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 32'h0) begin
            errors++;
            $display("FAIL reset tip %b mosi %b done %b rx %h want all 0",
                     bus.tip, bus.mosi, bus.done, bus.rx_data);
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.tip !== 1'b0) begin
            errors++;
            $display("FAIL reset_release tip got %b want 0", bus.tip);
        end
    endtask

    task automatic test_mode0();
        xfer(8, 1'b0, 32'hA5, 1'b0, 0, 32'h0, 0, 1'b0, "mode0");
        checks++;
        if (bus.rx_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL mode0 rx_const got %h want 000000a5", bus.rx_data);
        end
        @(negedge sys_clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mode0 done_width got %b want 0", bus.done);
        end
    endtask

    task automatic test_mode1();
        xfer(8, 1'b0, 32'hA5, 1'b1, 0, 32'h0, 0, 1'b0, "mode1");
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_len32_lsb();
        xfer(32, 1'b1, 32'h1234_5678, 1'b0, 1, 32'h0, 0, 1'b0, "len32");
        checks++;
        if (bus.rx_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL len32 rx_const got %h want ffffffff", bus.rx_data);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_len3();
        xfer(3, 1'b0, 32'hFFFF_FFF9, 1'b0, 2, 32'h3, 0, 1'b0, "len3");
        checks++;
        if (bus.rx_data !== 32'h0000_0006) begin
            errors++;
            $display("FAIL len3 rx_const got %h want 00000006", bus.rx_data);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_ignored_inputs();
        xfer(8, 1'b1, 32'h3C, 1'b0, 0, 32'h0, 0, 1'b1, "ignored");
        @(negedge sys_clk);
        bus.miso   = 1'b1;
        bus.sample = 1'b1;
        @(negedge sys_clk);
        bus.sample = 1'b0;
        pulse_shift();
        @(negedge sys_clk);
        checks++;
        if (bus.rx_data !== 32'h0000_003C || bus.tip !== 1'b0 || bus.done !== 1'b0 || bus.mosi !== 1'b0) begin
            errors++;
            $display("FAIL idle_pulses rx %h tip %b done %b mosi %b want 0000003c 0 0 0",
                     bus.rx_data, bus.tip, bus.done, bus.mosi);
        end
    endtask

    task automatic test_back_to_back();
        xfer(8, 1'b0, 32'h5A, 1'b0, 0, 32'h0, 0, 1'b0, "b2b_first");
        xfer(4, 1'b1, 32'h9, 1'b1, 2, 32'h5, 0, 1'b0, "b2b_second");
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset_abort();
        xfer(8, 1'b0, 32'hC3, 1'b0, 0, 32'h0, 4, 1'b0, "abort");
        exp_mosi_q.delete();
        exp_rx_q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tip !== 1'b0 || bus.mosi !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset tip %b mosi %b done %b rx %h want all 0",
                     bus.tip, bus.mosi, bus.done, bus.rx_data);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge sys_clk);
            checks++;
            if (bus.done !== 1'b0 || bus.tip !== 1'b0) begin
                errors++;
                $display("FAIL abort_release cycle %0d done %b tip %b want 0 0", k, bus.done, bus.tip);
            end
        end
        xfer(8, 1'b0, 32'h96, 1'b0, 0, 32'h0, 0, 1'b0, "after_abort");
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        bus.go      = 1'b0;
        bus.len     = '0;
        bus.lsb     = 1'b0;
        bus.tx_data = '0;
        bus.shift   = 1'b0;
        bus.sample  = 1'b0;
        bus.miso    = 1'b0;
        test_reset();
        test_mode0();
        test_mode1();
        test_len32_lsb();
        test_len3();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
